// File: rtl/motor_mode_drive.sv
// Two-wheel motor drive: maps the sel_type mode code to wheel directions and PWM,
// with a soft duty ramp, a forced brake before any reversal, and an emergency stop.
module motor_mode_drive #(
    parameter int PWM_PERIOD    = 1000,
    parameter int DUTY_W        = 10,
    parameter int DUTY_RUN      = 800,
    parameter int DUTY_TURN     = 500,
    parameter int DUTY_STEP     = 10,
    parameter int RAMP_STEP_CYC = 50000,
    parameter int BRAKE_CYC     = 500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] sel_type,
    input  logic       estop,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [1:0] cur_mode,
    output logic       busy
);

    localparam int RAMP_W  = $clog2(RAMP_STEP_CYC + 1);
    localparam int BRAKE_W = $clog2(BRAKE_CYC + 1);

    localparam logic [DUTY_W-1:0]  RUN_V      = DUTY_W'(DUTY_RUN);
    localparam logic [DUTY_W-1:0]  TURN_V     = DUTY_W'(DUTY_TURN);
    localparam logic [DUTY_W-1:0]  STEP_V     = DUTY_W'(DUTY_STEP);
    localparam logic [DUTY_W-1:0]  PWM_LAST   = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_STEP_CYC - 1);
    localparam logic [BRAKE_W-1:0] BRAKE_LAST = BRAKE_W'(BRAKE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRAKE,
        S_RAMP,
        S_RUN
    } state_e;

    state_e             state_q;
    logic [1:0]         sel_q;
    logic [1:0]         cur_mode_q;
    logic [DUTY_W-1:0]  duty_q;
    logic [DUTY_W-1:0]  shadow_q;
    logic [DUTY_W-1:0]  target_q;
    logic [DUTY_W-1:0]  pwm_cnt_q;
    logic [RAMP_W-1:0]  ramp_cnt_q;
    logic [BRAKE_W-1:0] brake_cnt_q;
    logic               dir_l_q;
    logic               dir_r_q;
    logic               pend_dir_l_q;
    logic               pend_dir_r_q;
    logic               pwm_q;

    logic [DUTY_W-1:0]  req_duty_d;
    logic               req_dir_l_d;
    logic               req_dir_r_d;
    logic               request_d;
    logic               dirs_change_d;
    logic               enter_brake_d;
    logic               enter_ramp_d;
    logic [DUTY_W-1:0]  ramp_target_d;
    logic [DUTY_W-1:0]  ramp_next_d;
    logic               ramp_tick_d;
    logic               pwm_wrap_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_duty_d  = '0;
        req_dir_l_d = dir_l_q;
        req_dir_r_d = dir_r_q;
        unique case (sel_q)
            2'b00: begin req_duty_d = '0;     req_dir_l_d = dir_l_q; req_dir_r_d = dir_r_q; end
            2'b01: begin req_duty_d = RUN_V;  req_dir_l_d = 1'b1;    req_dir_r_d = 1'b1;    end
            2'b10: begin req_duty_d = TURN_V; req_dir_l_d = 1'b0;    req_dir_r_d = 1'b1;    end
            2'b11: begin req_duty_d = TURN_V; req_dir_l_d = 1'b1;    req_dir_r_d = 1'b0;    end
        endcase

        request_d     = (sel_q != cur_mode_q);
        dirs_change_d = (req_dir_l_d != dir_l_q) || (req_dir_r_d != dir_r_q);
        // A request during BRAKE always re-arms the brake, whatever its direction.
        enter_brake_d = request_d && ((state_q == S_BRAKE) || dirs_change_d);
        enter_ramp_d  = request_d && !enter_brake_d && ((state_q == S_IDLE) || (state_q == S_RUN));

        ramp_target_d = (request_d && !dirs_change_d) ? req_duty_d : target_q;
        ramp_next_d   = duty_q;
        if (duty_q < ramp_target_d) begin
            ramp_next_d = ((ramp_target_d - duty_q) <= STEP_V) ? ramp_target_d : duty_q + STEP_V;
        end else if (duty_q > ramp_target_d) begin
            ramp_next_d = ((duty_q - ramp_target_d) <= STEP_V) ? ramp_target_d : duty_q - STEP_V;
        end

        ramp_tick_d = (ramp_cnt_q == RAMP_LAST);
        pwm_wrap_d  = (pwm_cnt_q == PWM_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 2'b00;
            cur_mode_q   <= 2'b00;
            duty_q       <= '0;
            shadow_q     <= '0;
            target_q     <= '0;
            pwm_cnt_q    <= '0;
            ramp_cnt_q   <= '0;
            brake_cnt_q  <= '0;
            dir_l_q      <= 1'b1;
            dir_r_q      <= 1'b1;
            pend_dir_l_q <= 1'b1;
            pend_dir_r_q <= 1'b1;
            pwm_q        <= 1'b0;
        end else begin
            sel_q     <= sel_type;
            pwm_cnt_q <= pwm_wrap_d ? '0 : pwm_cnt_q + 1'b1;
            pwm_q     <= (pwm_cnt_q < shadow_q);
            // Shadow only follows duty at the period boundary to avoid runt pulses.
            if (pwm_wrap_d) shadow_q <= duty_q;

            if (estop) begin
                state_q    <= S_IDLE;
                cur_mode_q <= 2'b00;
                duty_q     <= '0;
                shadow_q   <= '0;
                pwm_q      <= 1'b0;
            end else begin
                if (request_d) begin
                    cur_mode_q <= sel_q;
                    target_q   <= req_duty_d;
                end

                if (enter_brake_d) begin
                    state_q      <= S_BRAKE;
                    duty_q       <= '0;
                    shadow_q     <= '0;
                    brake_cnt_q  <= '0;
                    pend_dir_l_q <= req_dir_l_d;
                    pend_dir_r_q <= req_dir_r_d;
                end else if (enter_ramp_d) begin
                    state_q    <= S_RAMP;
                    ramp_cnt_q <= '0;
                end else begin
                    unique case (state_q)
                        S_IDLE: duty_q <= '0;
                        S_BRAKE: begin
                            if (brake_cnt_q == BRAKE_LAST) begin
                                state_q    <= S_RAMP;
                                ramp_cnt_q <= '0;
                                dir_l_q    <= pend_dir_l_q;
                                dir_r_q    <= pend_dir_r_q;
                            end else begin
                                brake_cnt_q <= brake_cnt_q + 1'b1;
                            end
                        end
                        S_RAMP: begin
                            if (duty_q == ramp_target_d) begin
                                state_q <= (ramp_target_d == '0) ? S_IDLE : S_RUN;
                            end else begin
                                ramp_cnt_q <= ramp_tick_d ? '0 : ramp_cnt_q + 1'b1;
                                if (ramp_tick_d) begin
                                    duty_q <= ramp_next_d;
                                    if (ramp_next_d == ramp_target_d)
                                        state_q <= (ramp_target_d == '0) ? S_IDLE : S_RUN;
                                end
                            end
                        end
                        S_RUN: ;
                    endcase
                end
            end
        end
    end

    assign pwm_l    = pwm_q;
    assign pwm_r    = pwm_q;
    assign dir_l    = dir_l_q;
    assign dir_r    = dir_r_q;
    assign cur_mode = cur_mode_q;
    assign busy     = (state_q == S_BRAKE) || (state_q == S_RAMP);

endmodule

// File: tb/tb_motor_mode_drive.sv
// Directed bench for motor_mode_drive with shortened timing parameters;
// expected values are hand-derived cycle counts from the mode/ramp/brake rules.
module tb_motor_mode_drive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic       estop;
    logic       pwm_l, pwm_r, dir_l, dir_r, busy;
    logic [1:0] cur_mode;

    int errors = 0;
    int checks = 0;
    int highs;
    int mism;

    motor_mode_drive #(
        .PWM_PERIOD   (10),
        .DUTY_W       (4),
        .DUTY_RUN     (8),
        .DUTY_TURN    (5),
        .DUTY_STEP    (2),
        .RAMP_STEP_CYC(4),
        .BRAKE_CYC    (8)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .sel_type (sel),
        .estop    (estop),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .dir_l    (dir_l),
        .dir_r    (dir_r),
        .cur_mode (cur_mode),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_pwm(input int n, output int hi, output int mm);
        hi = 0;
        mm = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (pwm_l === 1'b1) hi++;
            if (pwm_l !== pwm_r) mm++;
        end
    endtask

    task automatic wait_not_busy(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (busy === 1'b0) break;
            tick(1);
        end
        check("busy_timeout", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sel   = 2'b00;
        estop = 1'b0;
        tick(3);
        check("rst_pwm_l", pwm_l, 0);
        check("rst_pwm_r", pwm_r, 0);
        check("rst_dir_l", dir_l, 1);
        check("rst_dir_r", dir_r, 1);
        check("rst_mode", cur_mode, 0);
        check("rst_busy", busy, 0);

        // 1: stop -> forward, ramp 2,4,6,8 with no brake
        rst_n = 1'b1;
        sel   = 2'b01;
        tick(2);
        check("t1_mode", cur_mode, 1);
        check("t1_busy", busy, 1);
        check("t1_duty0", dut.duty_q, 0);
        tick(4); check("t1_duty2", dut.duty_q, 2);
        tick(4); check("t1_duty4", dut.duty_q, 4);
        tick(4); check("t1_duty6", dut.duty_q, 6);
        check("t1_busy6", busy, 1);
        tick(4); check("t1_duty8", dut.duty_q, 8);
        check("t1_busy8", busy, 0);
        tick(20);
        count_pwm(10, highs, mism);
        check("t1_highs", highs, 8);
        check("t1_lr_eq", mism, 0);
        check("t1_dir_l", dir_l, 1);
        check("t1_dir_r", dir_r, 1);

        // 2: forward -> spin left needs an 8-cycle brake, ramp saturates at 5
        sel = 2'b10;
        tick(2);
        check("t2_busy", busy, 1);
        check("t2_mode", cur_mode, 2);
        check("t2_duty0", dut.duty_q, 0);
        count_pwm(7, highs, mism);
        check("t2_brake_pwm", highs, 0);
        check("t2_dir_l_hold", dir_l, 1);
        tick(1);
        check("t2_dir_l", dir_l, 0);
        check("t2_dir_r", dir_r, 1);
        check("t2_busy_ramp", busy, 1);
        tick(4); check("t2_duty2", dut.duty_q, 2);
        tick(4); check("t2_duty4", dut.duty_q, 4);
        tick(4); check("t2_duty5", dut.duty_q, 5);
        check("t2_busy5", busy, 0);
        tick(20);
        count_pwm(10, highs, mism);
        check("t2_highs", highs, 5);

        // 3: back to forward, then stop ramps down 6,4,2,0
        sel = 2'b01;
        tick(2);
        wait_not_busy(100);
        check("t3_mode_fwd", cur_mode, 1);
        check("t3_duty8", dut.duty_q, 8);
        sel = 2'b00;
        tick(2);
        check("t3_mode", cur_mode, 0);
        check("t3_busy", busy, 1);
        tick(4); check("t3_duty6", dut.duty_q, 6);
        tick(4); check("t3_duty4", dut.duty_q, 4);
        tick(4); check("t3_duty2", dut.duty_q, 2);
        tick(4); check("t3_duty0", dut.duty_q, 0);
        check("t3_busy0", busy, 0);
        tick(20);
        count_pwm(10, highs, mism);
        check("t3_highs", highs, 0);
        check("t3_dir_l", dir_l, 1);
        check("t3_dir_r", dir_r, 1);

        // 4: estop during ramp at duty 4, then restart from 0
        sel = 2'b01;
        tick(2);
        check("t4_busy", busy, 1);
        tick(8);
        check("t4_duty4", dut.duty_q, 4);
        estop = 1'b1;
        tick(1);
        check("t4_es_pwm", pwm_l, 0);
        check("t4_es_mode", cur_mode, 0);
        check("t4_es_busy", busy, 0);
        check("t4_es_duty", dut.duty_q, 0);
        tick(3);
        check("t4_es_pwm_hold", pwm_l, 0);
        check("t4_es_busy_hold", busy, 0);
        check("t4_es_dir_l", dir_l, 1);
        estop = 1'b0;
        tick(1);
        check("t4_rel_busy", busy, 1);
        check("t4_rel_mode", cur_mode, 1);
        check("t4_rel_duty", dut.duty_q, 0);
        tick(4);
        check("t4_duty2", dut.duty_q, 2);

        // 5: request stop mid-ramp at duty 4, ramp turns around without brake
        tick(4);
        check("t5_duty4", dut.duty_q, 4);
        sel = 2'b00;
        tick(2);
        check("t5_mode", cur_mode, 0);
        check("t5_busy", busy, 1);
        check("t5_duty_hold", dut.duty_q, 4);
        tick(2); check("t5_duty2", dut.duty_q, 2);
        tick(4); check("t5_duty0", dut.duty_q, 0);
        check("t5_busy0", busy, 0);
        check("t5_dir_l", dir_l, 1);

        // 6: reset mid-brake, then spin right from reset
        sel = 2'b10;
        tick(2);
        check("t6_brake_busy", busy, 1);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_pwm", pwm_l, 0);
        check("t6_rst_dir_l", dir_l, 1);
        check("t6_rst_dir_r", dir_r, 1);
        check("t6_rst_mode", cur_mode, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_duty", dut.duty_q, 0);
        sel   = 2'b11;
        rst_n = 1'b1;
        tick(2);
        check("t6_busy", busy, 1);
        check("t6_mode", cur_mode, 3);
        tick(7);
        check("t6_dir_r_hold", dir_r, 1);
        tick(1);
        check("t6_dir_l", dir_l, 1);
        check("t6_dir_r", dir_r, 0);
        tick(4); check("t6_duty2", dut.duty_q, 2);
        tick(4); check("t6_duty4", dut.duty_q, 4);
        tick(4); check("t6_duty5", dut.duty_q, 5);
        check("t6_busy5", busy, 0);
        tick(20);
        count_pwm(10, highs, mism);
        check("t6_highs", highs, 5);
        check("t6_lr_eq", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
